// File: rtl/switch_mcu_pkg.sv
// Shared core definitions: register-file geometry and the address/data types
// used by the decoder, the ALUs and the register file.
package switch_mcu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_NUM    = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/switch_mcu_regfile_if.sv
// ALU-facing register port bundle: two read ports and one write port.
// master = ALU side (drives requests), slave = register file (drives read data).
interface switch_mcu_regfile_if #(
    parameter int DATA_W = switch_mcu_pkg::XLEN,
    parameter int ADDR_W = switch_mcu_pkg::REG_ADDR_W
);

    logic              in_ren_1;
    logic [ADDR_W-1:0] in_raddr_1;
    logic [DATA_W-1:0] out_rdata_1;
    logic              in_ren_2;
    logic [ADDR_W-1:0] in_raddr_2;
    logic [DATA_W-1:0] out_rdata_2;
    logic              in_wen;
    logic [ADDR_W-1:0] in_waddr;
    logic [DATA_W-1:0] in_wdata;

    modport master (
        output in_ren_1, in_raddr_1, in_ren_2, in_raddr_2,
        output in_wen, in_waddr, in_wdata,
        input  out_rdata_1, out_rdata_2
    );

    modport slave (
        input  in_ren_1, in_raddr_1, in_ren_2, in_raddr_2,
        input  in_wen, in_waddr, in_wdata,
        output out_rdata_1, out_rdata_2
    );

endinterface

// File: rtl/switch_mcu_regfile_rdport.sv
// One registered read port: holds its output while idle, forces x0 to zero and,
// when SWITCH_MCU_REGFILE_BYPASS_EN is defined, forwards same-edge write data.
module switch_mcu_regfile_rdport
    import switch_mcu_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              ren,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] stored_val,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

`ifndef SWITCH_MCU_REGFILE_BYPASS_EN
    // Write-side inputs only feed the bypass mux.
    logic unused_wr;
    assign unused_wr = ^{wen, waddr, wdata};
`endif

    always_comb begin
        rdata_d = rdata_q;
        if (ren) begin
            if (raddr == '0) begin
                rdata_d = '0;
`ifdef SWITCH_MCU_REGFILE_BYPASS_EN
            end else if (wen && (waddr == raddr)) begin
                rdata_d = wdata;
`endif
            end else begin
                rdata_d = stored_val;
            end
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/switch_mcu_regfile.sv
// General-purpose register file: storage and write logic plus two read ports.
// Optional write-through bypass is selected by SWITCH_MCU_REGFILE_BYPASS_EN.
module switch_mcu_regfile
    import switch_mcu_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DEPTH  = REG_NUM
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    switch_mcu_regfile_if.slave  bus
);

    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DATA_W-1:0] regs_q [DEPTH];

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_comb begin
        regs_d = regs_q;
        if (bus.in_wen && (bus.in_waddr != '0)) begin
            regs_d[bus.in_waddr] = bus.in_wdata;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    switch_mcu_regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rdport_1 (
        .in_clk     (in_clk),
        .in_rst     (in_rst),
        .ren        (bus.in_ren_1),
        .raddr      (bus.in_raddr_1),
        .stored_val (regs_q[bus.in_raddr_1]),
        .wen        (bus.in_wen),
        .waddr      (bus.in_waddr),
        .wdata      (bus.in_wdata),
        .rdata      (bus.out_rdata_1)
    );

    switch_mcu_regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rdport_2 (
        .in_clk     (in_clk),
        .in_rst     (in_rst),
        .ren        (bus.in_ren_2),
        .raddr      (bus.in_raddr_2),
        .stored_val (regs_q[bus.in_raddr_2]),
        .wen        (bus.in_wen),
        .waddr      (bus.in_waddr),
        .wdata      (bus.in_wdata),
        .rdata      (bus.out_rdata_2)
    );

endmodule

// File: tb/tb_switch_mcu_regfile.sv
// Self-checking bench for switch_mcu_regfile: directed scenarios then random traffic,
// all compared against an array-based model of the register file.
module tb_switch_mcu_regfile;

    logic in_clk = 1'b0;
    logic in_rst = 1'b0;

    switch_mcu_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    switch_mcu_regfile #(.DATA_W(32), .ADDR_W(5), .DEPTH(32)) dut (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .bus    (bus.slave)
    );

    always #5 in_clk = ~in_clk;

    int checks = 0;
    int errors = 0;

`ifdef SWITCH_MCU_REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [31:0] mem [32];
    logic [31:0] exp1;
    logic [31:0] exp2;

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic w,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (BYPASS && w && (wa == a)) return wd;
        return mem[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        exp1 = 32'd0;
        exp2 = 32'd0;
    endtask

    // Called at a negedge: drive, let one rising edge pass, update model, check at the next negedge.
    task automatic step(input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2,
                        input logic w, input logic [4:0] wa, input logic [31:0] wd, input string tag);
        bus.in_ren_1   = r1;
        bus.in_raddr_1 = a1;
        bus.in_ren_2   = r2;
        bus.in_raddr_2 = a2;
        bus.in_wen     = w;
        bus.in_waddr   = wa;
        bus.in_wdata   = wd;
        @(posedge in_clk);
        if (r1) exp1 = model_read(a1, w, wa, wd);
        if (r2) exp2 = model_read(a2, w, wa, wd);
        if (w && wa != 5'd0) mem[wa] = wd;
        @(negedge in_clk);
        check({tag, "_p1"}, bus.out_rdata_1, exp1);
        check({tag, "_p2"}, bus.out_rdata_2, exp2);
    endtask

    task automatic idle(input string tag);
        step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, tag);
    endtask

    initial begin
        bus.in_ren_1 = 1'b0; bus.in_raddr_1 = '0;
        bus.in_ren_2 = 1'b0; bus.in_raddr_2 = '0;
        bus.in_wen = 1'b0;   bus.in_waddr = '0; bus.in_wdata = '0;
        model_reset();
        repeat (2) @(negedge in_clk);
        check("reset_p1", bus.out_rdata_1, 32'd0);
        check("reset_p2", bus.out_rdata_2, 32'd0);
        in_rst = 1'b1;

        // 1: read after reset, then async reset in the middle of a read
        step(1, 5'd5, 0, 5'd0, 0, 5'd0, 32'd0, "t1_rd_x5");
        step(0, 5'd0, 0, 5'd0, 1, 5'd9, 32'h0000_0055, "t1_wr_x9");
        step(1, 5'd9, 1, 5'd9, 0, 5'd0, 32'd0, "t1_rd_x9");
        check("t1_pre_rst_val", bus.out_rdata_1, 32'h0000_0055);
        bus.in_ren_1 = 1'b1; bus.in_raddr_1 = 5'd9;
        #2 in_rst = 1'b0;
        #1;
        model_reset();
        check("t1_async_rst_p1", bus.out_rdata_1, 32'd0);
        check("t1_async_rst_p2", bus.out_rdata_2, 32'd0);
        @(negedge in_clk);
        check("t1_in_rst_hold", bus.out_rdata_1, 32'd0);
        in_rst = 1'b1;
        step(1, 5'd9, 0, 5'd0, 0, 5'd0, 32'd0, "t1_x9_cleared");

        // 2: write then read on port 2, then hold while idle
        step(0, 5'd0, 0, 5'd0, 1, 5'd7, 32'hDEAD_BEEF, "t2_wr_x7");
        step(0, 5'd0, 1, 5'd7, 0, 5'd0, 32'd0, "t2_rd_x7");
        check("t2_x7_value", bus.out_rdata_2, 32'hDEAD_BEEF);
        step(0, 5'd0, 0, 5'd3, 0, 5'd0, 32'd0, "t2_hold1");
        step(0, 5'd0, 0, 5'd0, 1, 5'd7, 32'h1111_2222, "t2_hold2");
        idle("t2_hold3");
        check("t2_held_value", bus.out_rdata_2, 32'hDEAD_BEEF);

        // 3: writes to x0 are dropped
        step(0, 5'd0, 0, 5'd0, 1, 5'd0, 32'h0000_1234, "t3_wr_x0");
        step(1, 5'd0, 1, 5'd0, 0, 5'd0, 32'd0, "t3_rd_x0");
        check("t3_x0_p1", bus.out_rdata_1, 32'd0);
        check("t3_x0_p2", bus.out_rdata_2, 32'd0);

        // 4: read-during-write collision
        step(0, 5'd0, 0, 5'd0, 1, 5'd3, 32'd5, "t4_wr_x3_5");
        step(1, 5'd3, 0, 5'd0, 1, 5'd3, 32'd9, "t4_collide");
        check("t4_collide_val", bus.out_rdata_1, BYPASS ? 32'd9 : 32'd5);
        step(1, 5'd3, 0, 5'd0, 0, 5'd0, 32'd0, "t4_reread");
        check("t4_committed", bus.out_rdata_1, 32'd9);

        // 5: dual read alongside an unrelated write
        step(0, 5'd0, 0, 5'd0, 1, 5'd4, 32'd10, "t5_wr_x4");
        step(1, 5'd3, 1, 5'd4, 1, 5'd6, 32'h0000_CAFE, "t5_dual");
        check("t5_p1_x3", bus.out_rdata_1, 32'd9);
        check("t5_p2_x4", bus.out_rdata_2, 32'd10);
        step(1, 5'd6, 1, 5'd6, 0, 5'd0, 32'd0, "t5_rd_x6");
        check("t5_x6", bus.out_rdata_1, 32'h0000_CAFE);

        // 6: ALU addi x8 = x3 + 7 over three cycles
        step(1, 5'd3, 0, 5'd0, 0, 5'd0, 32'd0, "t6_cnt1");
        step(0, 5'd0, 0, 5'd0, 0, 5'd0, 32'd0, "t6_cnt2");
        check("t6_cnt2_stable", bus.out_rdata_1, 32'd9);
        step(0, 5'd0, 0, 5'd0, 1, 5'd8, bus.out_rdata_1 + 32'd7, "t6_cnt3");
        check("t6_cnt3_stable", bus.out_rdata_1, 32'd9);
        step(0, 5'd0, 1, 5'd8, 0, 5'd0, 32'd0, "t6_rd_rd");
        check("t6_rd_value", bus.out_rdata_2, 32'd16);

        // Random traffic with frequent address collisions
        for (int n = 0; n < 400; n++) begin
            logic [4:0] a1, a2, wa;
            a1 = 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
            wa = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 31));
            step(1'($urandom_range(0, 1)), a1, 1'($urandom_range(0, 1)), a2,
                 1'($urandom_range(0, 1)), wa, $urandom, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
